resonator: RTL and testbench

Impact-sound synthesiser directly downstream of the frame/collision orchestrator. Consumes its `trigger_resonator`, `update_resonator` and `tension` outputs, runs a phase-accumulated triangle oscillator under a decaying amplitude envelope, and drives a 1-bit audio pin through an on-chip DAC stage.

---
 rtl/resonator_pkg.sv | 9 +
 rtl/resonator_if.sv | 12 +
 rtl/resonator_audio_dac.sv | 23 ++
 rtl/resonator.sv | 49 ++++
 tb/tb_resonator.sv | 129 ++++++++++++
 5 files changed

// File: rtl/resonator_pkg.sv
// resonator_pkg: shared widths and the trigger-to-envelope load function
package resonator_pkg;
  localparam int PHASE_W = 10;
  localparam int ENV_W = 8;
  localparam int SAMPLE_W = 8;
  function automatic logic [ENV_W-1:0] strike_env(input logic [2:0] t);
    return {t, 5'b11111};
  endfunction
endpackage

// File: rtl/resonator_if.sv
// resonator_if: orchestrator-to-resonator strobes in, sample/active/audio out
// master = orchestrator side, slave = resonator side
interface resonator_if;
  logic update;
  logic [2:0] trigger;
  logic [3:0] tension;
  logic [resonator_pkg::SAMPLE_W-1:0] sample;
  logic active;
  logic audio_out;
  modport master(output update, trigger, tension, input sample, active, audio_out);
  modport slave(input update, trigger, tension, output sample, active, audio_out);
endinterface

// File: rtl/resonator_audio_dac.sv
// audio_dac: 1-bit DAC (clk, rst, sample in; audio_out out); RESONATOR_SIGMA_DELTA_EN selects sigma-delta, else PWM
module audio_dac
  import resonator_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                audio_out
);
`ifdef RESONATOR_SIGMA_DELTA_EN
  logic [SAMPLE_W:0] acc;
  always_ff @(posedge clk)
    acc <= rst ? '0 : {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, sample};
  // carry out of the accumulator is the pulse density output
  assign audio_out = acc[SAMPLE_W];
`else
  logic [SAMPLE_W-1:0] pwm_cnt;
  always_ff @(posedge clk) begin
    pwm_cnt <= rst ? '0 : pwm_cnt + SAMPLE_W'(1);
    audio_out <= rst ? 1'b0 : pwm_cnt < sample;
  end
`endif
endmodule

// File: rtl/resonator.sv
// resonator: triangle oscillator under decaying envelope; ports clk, rst, bus (resonator_if.slave); DAC build macro RESONATOR_SIGMA_DELTA_EN
module resonator
  import resonator_pkg::*;
#(
  parameter int DECAY_SHIFT = 4,
  parameter int INC_SHIFT = 2
) (
  input logic        clk,
  input logic        rst,
  resonator_if.slave bus
);
  logic [PHASE_W-1:0] phase, inc;
  logic [ENV_W-1:0] env, shifted, dec;
  logic [8:0] tri9;
  logic [7:0] tri8;
  logic [15:0] prod;
  always_comb begin
    inc = PHASE_W'(bus.tension) << INC_SHIFT;
    shifted = env >> DECAY_SHIFT;
    dec = shifted == '0 ? ENV_W'(1) : shifted;
    tri9 = phase[9] ? ~phase[8:0] : phase[8:0];
    tri8 = tri9[8:1];
    prod = {8'd0, tri8} * {8'd0, env};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      env <= '0;
      bus.sample <= '0;
    end else begin
      bus.sample <= prod[15:8];
      // a strike swallows any coincident update
      if (bus.trigger != 3'd0) begin
        env <= strike_env(bus.trigger);
        phase <= '0;
      end else if (bus.update) begin
        phase <= phase + inc;
        if (env != '0) env <= env - dec;
      end
    end
  end
  assign bus.active = env != '0;
  audio_dac u_dac (
    .clk(clk),
    .rst(rst),
    .sample(bus.sample),
    .audio_out(bus.audio_out)
  );
endmodule

// File: tb/tb_resonator.sv
// tb_resonator: directed and random checks of resonator against an arithmetic reference model
module tb_resonator;
  logic clk = 0, rst = 1, dac_rst = 1;
  logic [7:0] dac_sample = 8'd128;
  logic dac_out;
  int checks = 0, failures = 0;
  int m_phase, m_env, m_sample, m_acc, m_cnt, m_audio;
  int ones, guard;
  resonator_if ifc ();
  resonator dut (.clk(clk), .rst(rst), .bus(ifc));
  audio_dac probe (.clk(clk), .rst(dac_rst), .sample(dac_sample), .audio_out(dac_out));
  always #5 clk = ~clk;
  function automatic int tri_val(input int p);
    return (p < 512 ? p : 1023 - p) / 2;
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_step(input int t, input int u, input int n);
    int dec;
    if (rst) begin
      {m_phase, m_env, m_sample, m_acc, m_cnt, m_audio} = '0;
      return;
    end
`ifdef RESONATOR_SIGMA_DELTA_EN
    m_acc = m_acc % 256 + m_sample;
    m_audio = m_acc >= 256 ? 1 : 0;
`else
    m_audio = m_cnt < m_sample ? 1 : 0;
    m_cnt = (m_cnt + 1) % 256;
`endif
    m_sample = tri_val(m_phase) * m_env / 256;
    if (t != 0) begin
      m_env = t * 32 + 31;
      m_phase = 0;
    end else if (u != 0) begin
      m_phase = (m_phase + n * 4) % 1024;
      dec = m_env / 16 == 0 ? 1 : m_env / 16;
      if (m_env != 0) m_env = m_env - dec;
    end
  endtask
  task automatic cyc(input int t, input int u, input int n);
    ifc.trigger = 3'(t);
    ifc.update = u[0];
    ifc.tension = 4'(n);
    @(posedge clk);
    model_step(t, u, n);
    #1;
    chk("env", int'(dut.env), m_env);
    chk("phase", int'(dut.phase), m_phase);
    chk("sample", int'(ifc.sample), m_sample);
    chk("active", int'(ifc.active), m_env != 0 ? 1 : 0);
    chk("audio_out", int'(ifc.audio_out), m_audio);
  endtask
  initial begin
    repeat (3) cyc(7, 1, 9);
    rst = 0;
    cyc(0, 0, 0);
    chk("rst_env", int'(dut.env), 0);
    chk("rst_sample", int'(ifc.sample), 0);
    chk("rst_active", int'(ifc.active), 0);
    chk("rst_audio", int'(ifc.audio_out), 0);
    cyc(7, 0, 0);
    chk("strike7_env", int'(dut.env), 255);
    chk("strike7_active", int'(ifc.active), 1);
    cyc(1, 0, 0);
    chk("strike1_env", int'(dut.env), 63);
    cyc(7, 0, 0);
    cyc(0, 1, 5);
    chk("upd_phase", int'(dut.phase), 20);
    chk("upd_env", int'(dut.env), 240);
    cyc(0, 0, 5);
    chk("upd_sample", int'(ifc.sample), 9);
    cyc(7, 0, 0);
    repeat (17) cyc(0, 1, 15);
    chk("pre_wrap_phase", int'(dut.phase), 1020);
    cyc(0, 1, 5);
    chk("wrap_phase", int'(dut.phase), 16);
    cyc(1, 0, 0);
    guard = 0;
    while (m_env != 10 && guard < 100) begin
      cyc(0, 1, 0);
      guard++;
    end
    chk("reach10", int'(dut.env), 10);
    cyc(0, 1, 0);
    chk("decay10", int'(dut.env), 9);
    guard = 0;
    while (m_env != 1 && guard < 100) begin
      cyc(0, 1, 0);
      guard++;
    end
    chk("reach1", int'(dut.env), 1);
    cyc(0, 1, 0);
    chk("decay1_env", int'(dut.env), 0);
    chk("decay1_active", int'(ifc.active), 0);
    cyc(0, 1, 3);
    chk("decay0_env", int'(dut.env), 0);
    cyc(3, 1, 5);
    chk("simul_env", int'(dut.env), 127);
    chk("simul_phase", int'(dut.phase), 0);
    cyc(7, 0, 0);
    repeat (4) cyc(0, 1, 6);
    rst = 1;
    cyc(5, 1, 6);
    rst = 0;
    chk("midrst_env", int'(dut.env), 0);
    chk("midrst_phase", int'(dut.phase), 0);
    cyc(0, 0, 0);
    repeat (600)
      cyc($urandom_range(0, 24) == 0 ? int'($urandom_range(1, 7)) : 0,
          int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    dac_rst = 1;
    cyc(0, 0, 0);
    dac_rst = 0;
    ones = 0;
    repeat (256) begin
      cyc(0, 0, 0);
      ones += int'(dac_out);
    end
    chk("dac_ones128", ones, 128);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
